// File: rtl/axi4_lite_slave_regs.sv
// ---------------------------------------------------------------------------
// axi4_lite_slave_regs
//
// AXI4-Lite responder that exposes NUM_REGS 32-bit read/write control
// registers. The write and read channels run as two independent two-state
// FSMs. Writes honour byte strobes and raise a one-cycle per-register
// pulse. Any access whose word address falls outside the bank completes
// with SLVERR. Every output comes straight from a flop.
//
// Ports
//   clk, reset_n           clock; asynchronous active-low reset
//   s_axi_aw*              write address channel (byte address)
//   s_axi_w*               write data channel with 4-bit byte strobe
//   s_axi_b*               write response (00 OKAY, 10 SLVERR)
//   s_axi_ar*              read address channel (byte address)
//   s_axi_r*               read data and response
//   reg_out                register i drives bits [32*i+31:32*i]
//   wr_pulse               bit i is high for one cycle after register i is written
// ---------------------------------------------------------------------------
module axi4_lite_slave_regs #(
    parameter int NUM_REGS = 8
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [31:0]              s_axi_awaddr,
    input  logic                     s_axi_awvalid,
    output logic                     s_axi_awready,
    input  logic [31:0]              s_axi_wdata,
    input  logic [3:0]               s_axi_wstrb,
    input  logic                     s_axi_wvalid,
    output logic                     s_axi_wready,
    output logic [1:0]               s_axi_bresp,
    output logic                     s_axi_bvalid,
    input  logic                     s_axi_bready,
    input  logic [31:0]              s_axi_araddr,
    input  logic                     s_axi_arvalid,
    output logic                     s_axi_arready,
    output logic [31:0]              s_axi_rdata,
    output logic [1:0]               s_axi_rresp,
    output logic                     s_axi_rvalid,
    input  logic                     s_axi_rready,
    output logic [NUM_REGS*32-1:0]   reg_out,
    output logic [NUM_REGS-1:0]      wr_pulse
);

    localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic { W_IDLE, W_RESP } w_state_e;
    typedef enum logic { R_IDLE, R_DATA } r_state_e;

    // Range check uses the full word address, so aliases above the bank
    // are rejected even when the index bits alone would decode.
    function automatic logic addr_in_range(input logic [31:0] addr);
        return {2'b00, addr[31:2]} < 32'(NUM_REGS);
    endfunction

    // Byte-lane bits are ignored by the decode.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    // Write channel state
    w_state_e             w_state_q,  w_state_d;
    logic                 awready_q,  awready_d;
    logic                 wready_q,   wready_d;
    logic                 aw_have_q,  aw_have_d;
    logic                 w_have_q,   w_have_d;
    logic                 aw_ok_q,    aw_ok_d;
    logic [IDX_W-1:0]     aw_idx_q,   aw_idx_d;
    logic [31:0]          wdata_q,    wdata_d;
    logic [3:0]           wstrb_q,    wstrb_d;
    logic                 bvalid_q,   bvalid_d;
    logic [1:0]           bresp_q,    bresp_d;
    logic [NUM_REGS-1:0]  wr_pulse_q, wr_pulse_d;
    logic [31:0]          regs_q [NUM_REGS];
    logic [31:0]          regs_d [NUM_REGS];

    // Read channel state
    r_state_e             r_state_q,  r_state_d;
    logic                 arready_q,  arready_d;
    logic                 rvalid_q,   rvalid_d;
    logic [31:0]          rdata_q,    rdata_d;
    logic [1:0]           rresp_q,    rresp_d;

    // Write FSM. Each address/data beat is latched on its own handshake and
    // its ready drops. The commit happens on the edge after both beats are
    // held, which keeps the register update off the input handshake path.
    always_comb begin
        // NOTE: every variable gets a default first so no path through the
        // case can leave a value unassigned and infer a latch.
        w_state_d  = w_state_q;
        awready_d  = awready_q;
        wready_d   = wready_q;
        aw_have_d  = aw_have_q;
        w_have_d   = w_have_q;
        aw_ok_d    = aw_ok_q;
        aw_idx_d   = aw_idx_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        wr_pulse_d = '0;
        regs_d     = regs_q;

        case (w_state_q)
            W_IDLE: begin
                if (aw_have_q && w_have_q) begin
                    if (aw_ok_q) begin
                        for (int b = 0; b < 4; b++) begin
                            if (wstrb_q[b]) regs_d[aw_idx_q][8*b +: 8] = wdata_q[8*b +: 8];
                        end
                        wr_pulse_d[aw_idx_q] = 1'b1;
                        bresp_d = RESP_OKAY;
                    end else begin
                        bresp_d = RESP_SLVERR;
                    end
                    aw_have_d = 1'b0;
                    w_have_d  = 1'b0;
                    bvalid_d  = 1'b1;
                    w_state_d = W_RESP;
                end else begin
                    if (s_axi_awvalid && awready_q) begin
                        aw_have_d = 1'b1;
                        awready_d = 1'b0;
                        aw_ok_d   = addr_in_range(s_axi_awaddr);
                        aw_idx_d  = s_axi_awaddr[IDX_W+1:2];
                    end else if (!aw_have_q) begin
                        awready_d = 1'b1;
                    end
                    if (s_axi_wvalid && wready_q) begin
                        w_have_d = 1'b1;
                        wready_d = 1'b0;
                        wdata_d  = s_axi_wdata;
                        wstrb_d  = s_axi_wstrb;
                    end else if (!w_have_q) begin
                        wready_d = 1'b1;
                    end
                end
            end
            W_RESP: begin
                if (s_axi_bready && bvalid_q) begin
                    bvalid_d  = 1'b0;
                    awready_d = 1'b1;
                    wready_d  = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // Read FSM. The data is sampled from the current register contents, so
    // a write committing on the same edge is not yet visible.
    always_comb begin
        r_state_d = r_state_q;
        arready_d = arready_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;

        case (r_state_q)
            R_IDLE: begin
                if (s_axi_arvalid && arready_q) begin
                    arready_d = 1'b0;
                    rvalid_d  = 1'b1;
                    if (addr_in_range(s_axi_araddr)) begin
                        rdata_d = regs_q[s_axi_araddr[IDX_W+1:2]];
                        rresp_d = RESP_OKAY;
                    end else begin
                        rdata_d = '0;
                        rresp_d = RESP_SLVERR;
                    end
                    r_state_d = R_DATA;
                end else begin
                    arready_d = 1'b1;
                end
            end
            R_DATA: begin
                if (s_axi_rready && rvalid_q) begin
                    rvalid_d  = 1'b0;
                    arready_d = 1'b1;
                    r_state_d = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            w_state_q  <= W_IDLE;
            awready_q  <= 1'b0;
            wready_q   <= 1'b0;
            aw_have_q  <= 1'b0;
            w_have_q   <= 1'b0;
            aw_ok_q    <= 1'b0;
            aw_idx_q   <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            wr_pulse_q <= '0;
            // NOTE: the register bank is user-visible control state that must
            // read as zero after reset, so it is reset here rather than being
            // left to a RAM with undefined contents.
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
            r_state_q  <= R_IDLE;
            arready_q  <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            rresp_q    <= RESP_OKAY;
        end else begin
            // NOTE: non-blocking assignments here so every flop samples the
            // pre-edge values, which keeps the two channels order-independent.
            w_state_q  <= w_state_d;
            awready_q  <= awready_d;
            wready_q   <= wready_d;
            aw_have_q  <= aw_have_d;
            w_have_q   <= w_have_d;
            aw_ok_q    <= aw_ok_d;
            aw_idx_q   <= aw_idx_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            wr_pulse_q <= wr_pulse_d;
            regs_q     <= regs_d;
            r_state_q  <= r_state_d;
            arready_q  <= arready_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            rresp_q    <= rresp_d;
        end
    end

    assign s_axi_awready = awready_q;
    assign s_axi_wready  = wready_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_arready = arready_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rdata   = rdata_q;
    assign s_axi_rresp   = rresp_q;
    assign wr_pulse      = wr_pulse_q;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_out
        assign reg_out[32*i +: 32] = regs_q[i];
    end

endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// ---------------------------------------------------------------------------
// tb_axi4_lite_slave_regs
//
// Self-checking bench for axi4_lite_slave_regs (NUM_REGS = 8). It runs a
// fixed vector table, hand-written multi-cycle sequences (beat ordering,
// backpressure, same-edge read/write, reset mid-transaction) and randomized
// traffic checked against an array-based register model.
// ---------------------------------------------------------------------------
module tb_axi4_lite_slave_regs;

    localparam int NR = 8;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [31:0]     s_axi_awaddr;
    logic            s_axi_awvalid;
    logic            s_axi_awready;
    logic [31:0]     s_axi_wdata;
    logic [3:0]      s_axi_wstrb;
    logic            s_axi_wvalid;
    logic            s_axi_wready;
    logic [1:0]      s_axi_bresp;
    logic            s_axi_bvalid;
    logic            s_axi_bready;
    logic [31:0]     s_axi_araddr;
    logic            s_axi_arvalid;
    logic            s_axi_arready;
    logic [31:0]     s_axi_rdata;
    logic [1:0]      s_axi_rresp;
    logic            s_axi_rvalid;
    logic            s_axi_rready;
    logic [NR*32-1:0] reg_out;
    logic [NR-1:0]   wr_pulse;

    axi4_lite_slave_regs #(.NUM_REGS(NR)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .reg_out       (reg_out),
        .wr_pulse      (wr_pulse)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_regs [NR];

    function automatic logic m_in_range(input logic [31:0] a);
        return (a >> 2) < NR;
    endfunction

    function automatic logic [1:0] m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        int idx;
        if (!m_in_range(a)) return 2'b10;
        idx = int'(a >> 2);
        for (int b = 0; b < 4; b++) if (s[b]) m_regs[idx][8*b +: 8] = d[8*b +: 8];
        return 2'b00;
    endfunction

    function automatic logic [NR-1:0] m_pulse(input logic [31:0] a);
        if (!m_in_range(a)) return '0;
        return NR'(1) << int'(a >> 2);
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        if (!m_in_range(a)) return 32'h0;
        return m_regs[int'(a >> 2)];
    endfunction

    function automatic logic [NR*32-1:0] m_vec();
        logic [NR*32-1:0] v;
        for (int i = 0; i < NR; i++) v[32*i +: 32] = m_regs[i];
        return v;
    endfunction

    function automatic void m_reset();
        for (int i = 0; i < NR; i++) m_regs[i] = 32'h0;
    endfunction

    // ---------------- bus tasks (drive/sample 1 time unit after posedge) ----
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int aw_dly, input int w_dly, input int b_dly,
                            output logic [1:0] resp, output logic [NR-1:0] pulse);
        bit aw_done = 0;
        bit w_done  = 0;
        bit aw_hs, w_hs;
        int cyc = 0;
        int lat = 0;
        logic [NR-1:0] p2;
        resp  = 'x;
        pulse = 'x;
        s_axi_awaddr = a;
        s_axi_wdata  = d;
        s_axi_wstrb  = s;
        s_axi_bready = 1'b0;
        while (!(aw_done && w_done) && cyc < 100) begin
            if (aw_done && !w_done) check("awready_low_waiting_w", s_axi_awready, 0);
            if (w_done && !aw_done) check("wready_low_waiting_aw", s_axi_wready, 0);
            s_axi_awvalid = !aw_done && (cyc >= aw_dly);
            s_axi_wvalid  = !w_done  && (cyc >= w_dly);
            aw_hs = s_axi_awvalid && s_axi_awready;
            w_hs  = s_axi_wvalid  && s_axi_wready;
            tick();
            if (aw_hs) aw_done = 1;
            if (w_hs)  w_done  = 1;
            cyc++;
        end
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        if (!(aw_done && w_done)) begin
            check("aw_w_handshake_timeout", 0, 1);
            return;
        end
        while (!s_axi_bvalid && lat < 50) begin
            tick();
            lat++;
        end
        check("b_latency", 32'(lat), 1);
        if (!s_axi_bvalid) return;
        resp  = s_axi_bresp;
        pulse = wr_pulse;
        check("readies_low_in_resp", {s_axi_awready, s_axi_wready}, 0);
        p2 = 'x;
        for (int i = 0; i < b_dly; i++) begin
            tick();
            if (i == 0) p2 = wr_pulse;
            check("b_hold", {s_axi_bvalid, s_axi_bresp, s_axi_awready, s_axi_wready},
                  {1'b1, resp, 2'b00});
        end
        s_axi_bready = 1'b1;
        tick();
        s_axi_bready = 1'b0;
        if (b_dly == 0) p2 = wr_pulse;
        check("wr_pulse_one_cycle", p2, 0);
        check("b_done_readies", {s_axi_bvalid, s_axi_awready, s_axi_wready}, 3'b011);
    endtask

    task automatic do_read(input logic [31:0] a, input int r_dly,
                           output logic [31:0] d, output logic [1:0] resp);
        bit hs = 0;
        int cyc = 0;
        d    = 'x;
        resp = 'x;
        s_axi_araddr = a;
        s_axi_rready = 1'b0;
        while (!hs && cyc < 100) begin
            s_axi_arvalid = 1'b1;
            hs = s_axi_arready;
            tick();
            cyc++;
        end
        s_axi_arvalid = 1'b0;
        if (!hs) begin
            check("ar_handshake_timeout", 0, 1);
            return;
        end
        check("rvalid_after_ar", {s_axi_rvalid, s_axi_arready}, 2'b10);
        d    = s_axi_rdata;
        resp = s_axi_rresp;
        for (int i = 0; i < r_dly; i++) begin
            tick();
            check("r_hold", {s_axi_rvalid, s_axi_rresp, s_axi_rdata}, {1'b1, resp, d});
        end
        s_axi_rready = 1'b1;
        tick();
        s_axi_rready = 1'b0;
        check("r_done", {s_axi_rvalid, s_axi_arready}, 2'b01);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
        logic [7:0]  exp_pulse;
    } vec_t;

    vec_t vecs [15];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [1:0]    resp;
        logic [NR-1:0] pulse;
        logic [31:0]   rd;

        vecs[0]  = '{0, 32'h0000_0000, 32'h0,         4'h0, 32'h0000_0000, 2'b00, 8'h00};
        vecs[1]  = '{1, 32'h0000_0004, 32'hDEADBEEF,  4'hF, 32'h0,         2'b00, 8'h02};
        vecs[2]  = '{0, 32'h0000_0004, 32'h0,         4'h0, 32'hDEADBEEF,  2'b00, 8'h00};
        vecs[3]  = '{1, 32'h0000_001C, 32'h12345678,  4'h3, 32'h0,         2'b00, 8'h80};
        vecs[4]  = '{0, 32'h0000_001C, 32'h0,         4'h0, 32'h0000_5678, 2'b00, 8'h00};
        vecs[5]  = '{1, 32'h0000_001E, 32'hAABBCCDD,  4'hC, 32'h0,         2'b00, 8'h80};
        vecs[6]  = '{0, 32'h0000_001D, 32'h0,         4'h0, 32'hAABB_5678, 2'b00, 8'h00};
        vecs[7]  = '{1, 32'h0000_0020, 32'hFFFFFFFF,  4'hF, 32'h0,         2'b10, 8'h00};
        vecs[8]  = '{0, 32'h0000_0020, 32'h0,         4'h0, 32'h0000_0000, 2'b10, 8'h00};
        vecs[9]  = '{0, 32'hFFFF_FFFC, 32'h0,         4'h0, 32'h0000_0000, 2'b10, 8'h00};
        vecs[10] = '{1, 32'h0000_0000, 32'h00000001,  4'h0, 32'h0,         2'b00, 8'h01};
        vecs[11] = '{0, 32'h0000_0000, 32'h0,         4'h0, 32'h0000_0000, 2'b00, 8'h00};
        vecs[12] = '{1, 32'h4000_0000, 32'hFFFFFFFF,  4'hF, 32'h0,         2'b10, 8'h00};
        vecs[13] = '{0, 32'h0000_0000, 32'h0,         4'h0, 32'h0000_0000, 2'b00, 8'h00};
        vecs[14] = '{0, 32'h0000_0004, 32'h0,         4'h0, 32'hDEADBEEF,  2'b00, 8'h00};

        reset_n = 1'b0;
        s_axi_awaddr = '0; s_axi_awvalid = 0; s_axi_wdata = '0; s_axi_wstrb = '0;
        s_axi_wvalid = 0; s_axi_bready = 0; s_axi_araddr = '0; s_axi_arvalid = 0;
        s_axi_rready = 0;
        m_reset();

        // ---- reset state ----
        repeat (3) tick();
        check("reset_ctrl_outputs",
              {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid,
               s_axi_bresp, s_axi_rresp, s_axi_rdata}, 0);
        check("reset_reg_out", reg_out, 0);
        check("reset_wr_pulse", wr_pulse, 0);
        reset_n = 1'b1;
        #1;
        check("readies_before_first_edge", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b000);
        tick();
        check("readies_after_first_edge", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);

        // ---- vector table ----
        foreach (vecs[i]) begin
            if (vecs[i].wr) begin
                do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, 0, 0, resp, pulse);
                void'(m_write(vecs[i].addr, vecs[i].data, vecs[i].strb));
                check($sformatf("vec%0d_bresp", i), resp, vecs[i].exp_resp);
                check($sformatf("vec%0d_wr_pulse", i), pulse, vecs[i].exp_pulse);
            end else begin
                do_read(vecs[i].addr, 0, rd, resp);
                check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_data);
                check($sformatf("vec%0d_rresp", i), resp, vecs[i].exp_resp);
            end
        end
        check("table_reg_out", reg_out, m_vec());

        // ---- byte strobes with W arriving three cycles before AW ----
        do_write(32'h08, 32'hAABBCCDD, 4'hF, 0, 0, 0, resp, pulse);
        void'(m_write(32'h08, 32'hAABBCCDD, 4'hF));
        do_write(32'h08, 32'h11223344, 4'b0101, 3, 0, 0, resp, pulse);
        void'(m_write(32'h08, 32'h11223344, 4'b0101));
        check("strb_bresp", resp, 2'b00);
        check("strb_pulse", pulse, 8'h04);
        check("strb_reg_out", reg_out[95:64], 32'hAA22CC44);
        do_read(32'h08, 0, rd, resp);
        check("strb_readback", rd, 32'hAA22CC44);

        // ---- backpressure: out-of-range write held 5 cycles, read held 5 ----
        do_write(32'h20, 32'h55555555, 4'hF, 0, 2, 5, resp, pulse);
        check("bp_bresp", resp, 2'b10);
        check("bp_no_pulse", pulse, 0);
        check("bp_regs_unchanged", reg_out, m_vec());
        do_read(32'h04, 5, rd, resp);
        check("bp_rdata", rd, 32'hDEADBEEF);

        // ---- read and write committing on the same edge ----
        do_write(32'h0C, 32'h01020304, 4'hF, 0, 0, 0, resp, pulse);
        void'(m_write(32'h0C, 32'h01020304, 4'hF));
        s_axi_awaddr = 32'h0C; s_axi_wdata = 32'hCAFEF00D; s_axi_wstrb = 4'hF;
        s_axi_awvalid = 1; s_axi_wvalid = 1;
        tick();
        s_axi_awvalid = 0; s_axi_wvalid = 0;
        s_axi_araddr = 32'h0C; s_axi_arvalid = 1;
        tick();
        s_axi_arvalid = 0;
        check("same_edge_old_rdata", {s_axi_rvalid, s_axi_rdata}, {1'b1, 32'h01020304});
        check("same_edge_write_done", {s_axi_bvalid, reg_out[127:96]}, {1'b1, 32'hCAFEF00D});
        void'(m_write(32'h0C, 32'hCAFEF00D, 4'hF));
        s_axi_bready = 1; s_axi_rready = 1;
        tick();
        s_axi_bready = 0; s_axi_rready = 0;
        check("same_edge_both_done", {s_axi_bvalid, s_axi_rvalid}, 2'b00);

        // ---- randomized traffic against the model ----
        for (int n = 0; n < 150; n++) begin
            logic [31:0] a, d;
            logic [3:0]  s;
            a = (32'($urandom_range(0, 9)) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) a = $urandom;
            d = $urandom;
            s = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                logic [NR-1:0] ep;
                logic [1:0]    er;
                ep = m_pulse(a);
                er = m_write(a, d, s);
                do_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3),
                         $urandom_range(0, 3), resp, pulse);
                check("rnd_bresp", resp, er);
                check("rnd_wr_pulse", pulse, ep);
                check("rnd_reg_out", reg_out, m_vec());
            end else begin
                do_read(a, $urandom_range(0, 3), rd, resp);
                check("rnd_rdata", rd, m_read(a));
                check("rnd_rresp", resp, m_in_range(a) ? 2'b00 : 2'b10);
            end
        end

        // ---- reset while both responses are pending ----
        s_axi_awaddr = 32'h10; s_axi_wdata = 32'h5A5A5A5A; s_axi_wstrb = 4'hF;
        s_axi_araddr = 32'h04;
        s_axi_awvalid = 1; s_axi_wvalid = 1; s_axi_arvalid = 1;
        tick();
        s_axi_awvalid = 0; s_axi_wvalid = 0; s_axi_arvalid = 0;
        tick();
        check("pre_reset_both_pending", {s_axi_bvalid, s_axi_rvalid}, 2'b11);
        #2;
        reset_n = 1'b0;
        #1;
        check("midreset_outputs",
              {s_axi_awready, s_axi_wready, s_axi_arready, s_axi_bvalid, s_axi_rvalid,
               s_axi_bresp, s_axi_rresp, s_axi_rdata, wr_pulse}, 0);
        check("midreset_regs", reg_out, 0);
        m_reset();
        tick();
        reset_n = 1'b1;
        tick();
        check("post_reset_readies", {s_axi_awready, s_axi_wready, s_axi_arready}, 3'b111);
        do_write(32'h18, 32'h0BADF00D, 4'hF, 0, 1, 0, resp, pulse);
        void'(m_write(32'h18, 32'h0BADF00D, 4'hF));
        check("post_reset_bresp", resp, 2'b00);
        check("post_reset_pulse", pulse, 8'h40);
        do_read(32'h18, 0, rd, resp);
        check("post_reset_rdata", rd, 32'h0BADF00D);
        do_read(32'h04, 0, rd, resp);
        check("post_reset_cleared", rd, 32'h0);
        check("post_reset_reg_out", reg_out, m_vec());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/axi4_lite_slave_regs.md
# axi4_lite_slave_regs

AXI4-Lite responder exposing a bank of NUM_REGS 32-bit read/write control registers to an AXI4-Lite initiator. It sits on the fabric side of the same bus our initiator-side blocks drive, and presents the register contents as flat outputs to user logic. Write and read channels run independently, with byte strobes, per-register write pulses and SLVERR on out-of-range addresses.

## Interface

- NUM_REGS, 8, number of 32-bit registers (1..256); IDX_W = max(1, clog2(NUM_REGS))
- clk  in  1  single clock, all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- s_axi_awaddr  in  32  write address (byte address)
- s_axi_awvalid  in  1  / s_axi_awready out 1
- s_axi_wdata  in  32  / s_axi_wstrb in 4  / s_axi_wvalid in 1  / s_axi_wready out 1
- s_axi_bresp  out  2  00 OKAY, 10 SLVERR
- s_axi_bvalid  out  1  / s_axi_bready in 1
- s_axi_araddr  in  32  / s_axi_arvalid in 1  / s_axi_arready out 1
- s_axi_rdata  out  32  / s_axi_rresp out 2  / s_axi_rvalid out 1  / s_axi_rready in 1
- reg_out  out  NUM_REGS*32  register i at bits [32*i+31:32*i]
- wr_pulse  out  NUM_REGS  one-cycle strobe per register written

## Operation

- Decode: index = addr[IDX_W+1:2]; addr[1:0] ignored; valid iff addr[31:2] < NUM_REGS.
- Write FSM states: W_IDLE, W_RESP.
  - W_IDLE: awready=1 and wready=1 until the respective beat is captured; each ready drops independently on its own handshake (AW and W may arrive in either order or the same cycle).
  - When both captured: commit write, go W_RESP. Valid address: each byte b with wstrb[b]=1 updated, others kept; bresp=00; wr_pulse[index]=1 for one cycle. Invalid address: no register change, no pulse, bresp=10.
  - W_RESP: bvalid=1 held with bresp stable until bready; on handshake bvalid<=0, awready<=1, wready<=1, return W_IDLE.
- Read FSM states: R_IDLE, R_DATA.
  - R_IDLE: arready=1; on handshake arready<=0, rdata<=register (or 0 if invalid), rresp<=00/10, rvalid<=1, go R_DATA.
  - R_DATA: rdata/rresp stable until rready; on handshake rvalid<=0, arready<=1, return R_IDLE.
- Read and write channels fully independent; simultaneous access to same register: read captures the value before a write committing on the same edge.
- Reset (asserted any time, including mid-transaction): all registers 0, awready/wready/arready/bvalid/rvalid 0, bresp/rresp 00, rdata 0, wr_pulse 0, FSMs to idle; pending beats discarded. Readies go 1 on the first rising edge after reset_n deasserts.

## Timing

- Write: final AW/W handshake at edge T -> at edge T+1 register updated, wr_pulse high, bvalid high (one cycle write latency).
- bvalid/bready handshake at edge T -> awready/wready high from edge T (ready for the next beat at edge T+1).
- Write throughput: one write per 3 cycles minimum when bready held 1.
- Read: AR handshake at edge T -> rvalid and rdata valid after edge T; rready=1 -> rvalid cleared at T+1, next AR accepted at T+2. Read throughput one per 2 cycles.
- No combinational path from any input to any output; all outputs registered.
- bvalid/rvalid never deassert without handshake (except reset).

## Test plan

- Reset: hold reset_n=0 -> all outputs 0; release -> awready, wready, arready = 1 after first edge; read addr 0x0 -> rdata 0x00000000, rresp 00.
- Full write/read: AW 0x04 and W 0xDEADBEEF strb 4'hF same cycle -> bvalid next cycle, bresp 00, wr_pulse[1] one cycle; read 0x04 -> 0xDEADBEEF.
- Byte strobes and ordering: W 0x11223344 strb 4'b0101 three cycles before AW 0x08 (reg preloaded 0xAABBCCDD) -> reg 2 = 0xAA22CC44; wready low while waiting for AW.
- Backpressure: bready=0 for 5 cycles -> bvalid and bresp held, awready/wready stay 0; rready=0 for 5 cycles -> rdata stable.
- Out of range (NUM_REGS=8): write 0x20 -> bresp 10, no wr_pulse, regs unchanged; read 0x20 -> rdata 0, rresp 10.
- Reset mid-transaction: assert reset_n=0 while bvalid=1 and rvalid=1 -> both drop immediately, registers 0, next write/read completes normally.
